// File: rtl/mult_hilo.sv
// Sequential radix-2 shift-add 32x32 multiplier holding the 64-bit product
// in architectural HI/LO registers, with MTHI/MTLO write access while idle.
module mult_hilo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             WrHi,
    input  logic             WrLo,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    count;
    logic             negate;

    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;
    logic [WIDTH:0]   sum_c;
    logic [PW-1:0]    result_c;
    logic             last_c;

    // Operand magnitudes; the most negative value maps onto itself and is
    // then correct when read as an unsigned magnitude.
    always_comb begin
        abs_a_c = A;
        abs_b_c = B;
        if (Signed && A[WIDTH-1]) abs_a_c = ~A + WIDTH'(1);
        if (Signed && B[WIDTH-1]) abs_b_c = ~B + WIDTH'(1);
    end

    // One shift-add step: the carry out of the upper half becomes the new msb.
    always_comb begin
        sum_c    = {1'b0, acc[PW-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : (WIDTH + 1)'(0));
        result_c = negate ? (~acc + PW'(1)) : acc;
        last_c   = (count == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = BUSY;
            BUSY:    if (last_c) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            negate <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Hi     <= '0;
            Lo     <= '0;
        end else begin
            Busy <= (state_nxt != IDLE);
            Done <= (state == FINISH);
            case (state)
                IDLE: begin
                    // A product started in this cycle later overwrites these writes.
                    if (WrHi) Hi <= WrData;
                    if (WrLo) Lo <= WrData;
                    if (Start) begin
                        mcand  <= abs_a_c;
                        mplier <= abs_b_c;
                        negate <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                BUSY: begin
                    acc    <= {sum_c, acc[WIDTH-1:1]};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    count  <= count + CW'(1);
                end
                FINISH: begin
                    Hi <= result_c[PW-1:WIDTH];
                    Lo <= result_c[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo.sv
// Self-checking bench for mult_hilo: products against a plain 64-bit
// arithmetic reference, latency, protocol and HI/LO write behaviour.
module tb_mult_hilo;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic        Signed;
    logic [31:0] A;
    logic [31:0] B;
    logic        WrHi;
    logic        WrLo;
    logic [31:0] WrData;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int checks;
    int failures;

    mult_hilo #(.WIDTH(32)) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .Start  (Start),
        .Signed (Signed),
        .A      (A),
        .B      (B),
        .WrHi   (WrHi),
        .WrLo   (WrLo),
        .WrData (WrData),
        .Busy   (Busy),
        .Done   (Done),
        .Hi     (Hi),
        .Lo     (Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // mode: 0 plain, 1 Start pulse (2*3) mid-busy, 2 HI/LO writes mid-busy,
    // 3 WrHi together with Start. mid_hi/mid_lo sampled at k=6 (k=0 for mode 3).
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int mode, input logic [31:0] wd,
                           output int done_at, output int busy_cycles,
                           output logic [31:0] mid_hi, output logic [31:0] mid_lo);
        int mid_k;
        mid_k = (mode == 3) ? 0 : 6;
        mid_hi = 'x;
        mid_lo = 'x;
        @(negedge Clk);
        A = a; B = b; Signed = s; Start = 1'b1;
        if (mode == 3) begin WrHi = 1'b1; WrData = wd; end
        @(negedge Clk);
        Start = 1'b0; WrHi = 1'b0;
        A = $urandom; B = $urandom; Signed = 1'($urandom);
        done_at = -1;
        busy_cycles = 0;
        for (int k = 0; k < 100; k++) begin
            if (k == mid_k) begin mid_hi = Hi; mid_lo = Lo; end
            if (Busy) busy_cycles++;
            if (Done) begin done_at = k; break; end
            if (mode == 1 && k == 5) begin Start = 1'b1; A = 32'd2; B = 32'd3; Signed = 1'b0; end
            if (mode == 1 && k == 6) Start = 1'b0;
            if (mode == 2 && k == 3) begin WrHi = 1'b1; WrData = wd; end
            if (mode == 2 && k == 4) begin WrHi = 1'b0; WrLo = 1'b1; end
            if (mode == 2 && k == 5) WrLo = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({Busy, Done, Hi, Lo} !== 66'd0) begin
            failures++;
            $display("FAIL reset_state: Busy=%b Done=%b Hi=%h Lo=%h, required all zero", Busy, Done, Hi, Lo);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_unsigned_max;
        int d, bc;
        logic [31:0] mh, ml;
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 32'd0, d, bc, mh, ml);
        checks++;
        if (d !== 33) begin
            failures++;
            $display("FAIL umax_latency: Done at edge %0d, required 33", d);
        end
        checks++;
        if (bc !== 33) begin
            failures++;
            $display("FAIL umax_busy_cycles: got %0d, required 33", bc);
        end
        checks++;
        if ({Hi, Lo} !== 64'hFFFF_FFFE_0000_0001) begin
            failures++;
            $display("FAIL umax_product: got %h_%h, required fffffffe_00000001", Hi, Lo);
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width: Done=%b one cycle later, required 0", Done);
        end
    endtask

    task automatic test_signed_corners;
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic        ts [4];
        logic [63:0] exp_p;
        int d, bc;
        logic [31:0] mh, ml;
        ta = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
        tb = '{32'h0000_0005, 32'h8000_0000, 32'h1234_5678, 32'h0000_0001};
        ts = '{1'b1, 1'b1, 1'b1, 1'b1};
        exp_p = 64'hFFFF_FFFF_FFFF_FFF1;
        for (int i = 0; i < 4; i++) begin
            do_mult(ta[i], tb[i], ts[i], 0, 32'd0, d, bc, mh, ml);
            if (i == 0) exp_p = 64'hFFFF_FFFF_FFFF_FFF1;
            else if (i == 1) exp_p = 64'h4000_0000_0000_0000;
            else if (i == 2) exp_p = 64'd0;
            else exp_p = 64'hFFFF_FFFF_8000_0000;
            checks++;
            if ({Hi, Lo} !== exp_p) begin
                failures++;
                $display("FAIL signed_corner_%0d: %h*%h got %h_%h, required %h", i, ta[i], tb[i], Hi, Lo, exp_p);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic        s;
        logic [63:0] exp_p;
        int d, bc;
        logic [31:0] mh, ml;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            if (i % 6 == 1) a = 32'h8000_0000;
            if (i % 6 == 2) b = 32'hFFFF_FFFF;
            exp_p = ref_prod(a, b, s);
            do_mult(a, b, s, 0, 32'd0, d, bc, mh, ml);
            checks++;
            if ({Hi, Lo} !== exp_p || d !== 33) begin
                failures++;
                $display("FAIL random_%0d: s=%b %h*%h got %h_%h at edge %0d, required %h at edge 33",
                         i, s, a, b, Hi, Lo, d, exp_p);
            end
        end
    endtask

    task automatic test_back_to_back;
        int d, bc, n;
        logic [31:0] mh, ml;
        do_mult(32'd7, 32'd9, 1'b0, 1, 32'd0, d, bc, mh, ml);
        checks++;
        if ({Hi, Lo} !== 64'd63 || d !== 33) begin
            failures++;
            $display("FAIL ignored_start: got %h_%h at edge %0d, required 0_0000003f at edge 33", Hi, Lo, d);
        end
        Start = 1'b1; A = 32'd2; B = 32'd3; Signed = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        for (n = 1; n < 100 && !Done; n++) @(negedge Clk);
        checks++;
        if (n !== 34) begin
            failures++;
            $display("FAIL back_to_back_gap: second Done %0d cycles later, required 34", n);
        end
        checks++;
        if (Hi !== 32'd0 || Lo !== 32'd6) begin
            failures++;
            $display("FAIL back_to_back_product: got %h_%h, required 00000000_00000006", Hi, Lo);
        end
    endtask

    task automatic test_mthi_mtlo;
        int d, bc;
        logic [31:0] mh, ml;
        @(negedge Clk);
        WrHi = 1'b1; WrData = 32'hDEAD_BEEF;
        @(negedge Clk);
        WrHi = 1'b0; WrLo = 1'b1; WrData = 32'h0000_CAFE;
        checks++;
        if (Hi !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL mthi_idle: Hi=%h, required deadbeef", Hi);
        end
        @(negedge Clk);
        WrLo = 1'b0;
        checks++;
        if (Lo !== 32'h0000_CAFE) begin
            failures++;
            $display("FAIL mtlo_idle: Lo=%h, required 0000cafe", Lo);
        end
        do_mult(32'd1000, 32'd3000, 1'b0, 2, 32'h1111_2222, d, bc, mh, ml);
        checks++;
        if (mh !== 32'hDEAD_BEEF || ml !== 32'h0000_CAFE) begin
            failures++;
            $display("FAIL write_during_busy: Hi=%h Lo=%h, required deadbeef 0000cafe", mh, ml);
        end
        checks++;
        if ({Hi, Lo} !== 64'd3000000) begin
            failures++;
            $display("FAIL product_after_writes: got %h_%h, required %h", Hi, Lo, 64'd3000000);
        end
        do_mult(32'hFFFF_FFFF, 32'd2, 1'b1, 3, 32'h5555_AAAA, d, bc, mh, ml);
        checks++;
        if (mh !== 32'h5555_AAAA) begin
            failures++;
            $display("FAIL write_with_start: Hi=%h, required 5555aaaa", mh);
        end
        checks++;
        if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            failures++;
            $display("FAIL product_after_write_start: got %h_%h, required ffffffff_fffffffe", Hi, Lo);
        end
    endtask

    task automatic test_reset_abort;
        int seen;
        @(negedge Clk);
        WrLo = 1'b1; WrData = 32'hA5A5_0001;
        @(negedge Clk);
        WrLo = 1'b0;
        A = 32'd12345; B = 32'd678; Signed = 1'b0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (10) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({Busy, Done, Hi, Lo} !== 66'd0) begin
            failures++;
            $display("FAIL reset_abort: Busy=%b Done=%b Hi=%h Lo=%h, required all zero", Busy, Done, Hi, Lo);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk);
            if (Done || Busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL no_done_after_reset: Done/Busy high in %0d cycles, required 0", seen);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        Reset_n = 1'b0;
        Start = 1'b0;
        Signed = 1'b0;
        A = '0;
        B = '0;
        WrHi = 1'b0;
        WrLo = 1'b0;
        WrData = '0;
        test_reset();
        test_unsigned_max();
        test_signed_corners();
        test_back_to_back();
        test_mthi_mtlo();
        test_random();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
